// File: rtl/for_ent_inverse_if.sv
// ---------------------------------------------------------------------------
// for_ent_inverse_if
//   Handshake bundle between a producer of the ForEnt relation
//   XOUT = ((COUNT+1)*A - B) mod 2^W and the inverse solver that recovers A.
//
//   Input side  : IN_VALID / IN_READY qualify the XOUT / B pair.
//   Output side : OUT_VALID / OUT_READY qualify the recovered operand A.
//
//   Modports
//     master : the environment (drives XOUT, B, IN_VALID, OUT_READY)
//     slave  : the solver      (drives IN_READY, OUT_VALID, A)
// ---------------------------------------------------------------------------
interface for_ent_inverse_if #(
  parameter int W = 8
);
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] XOUT;
  logic [W-1:0] B;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] A;

  modport master (
    output IN_VALID, XOUT, B, OUT_READY,
    input  IN_READY, OUT_VALID, A
  );

  modport slave (
    input  IN_VALID, XOUT, B, OUT_READY,
    output IN_READY, OUT_VALID, A
  );
endinterface

// File: rtl/for_ent_inverse.sv
// ---------------------------------------------------------------------------
// for_ent_inverse
//   Recovers A from XOUT = (K*A - B) mod 2^W with K = (COUNT+1) mod 2^W odd.
//   With S = XOUT + B, A is the unique solution of K*A = S (mod 2^W).
//   The solver resolves one bit of A per clock, LSB first, without a
//   multiplier or inverse table: W cycles from acceptance to OUT_VALID.
//
//   Ports
//     CLK : clock, all state changes on the rising edge
//     RST : synchronous active-high reset
//     bus : for_ent_inverse_if.slave
//           IN_VALID/IN_READY/XOUT/B   input transaction
//           OUT_VALID/OUT_READY/A      recovered operand
// ---------------------------------------------------------------------------
module for_ent_inverse #(
  parameter int W     = 8,
  parameter int COUNT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  for_ent_inverse_if.slave  bus
);

  localparam int           IDX_W    = $clog2(W) + 1;
  localparam logic [W-1:0] K        = W'(COUNT + 1);
  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  // An even multiplier has no inverse modulo 2^W, so A would not be unique.
  if (K[0] == 1'b0) begin : g_even_k
    $fatal(1, "for_ent_inverse: K = COUNT+1 must be odd");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOLVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     s_q,     s_d;     // target product XOUT + B
  logic [W-1:0]     acc_q,   acc_d;   // running K * A for the bits resolved so far
  logic [W-1:0]     a_q,     a_d;     // recovered operand
  logic [IDX_W-1:0] idx_q,   idx_d;   // bit currently being resolved

  logic [W-1:0]     diff;
  logic [W-1:0]     diff_shr;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    acc_d    = acc_q;
    a_d      = a_q;
    idx_d    = idx_q;
    // Bits below idx of S - acc are already zero; bit idx decides A[idx].
    diff     = s_q - acc_q;
    diff_shr = diff >> idx_q;

    unique case (state_q)
      IDLE: begin
        if (bus.IN_VALID) begin
          s_d     = bus.XOUT + bus.B;
          acc_d   = '0;
          a_d     = '0;
          idx_d   = '0;
          state_d = SOLVE;
        end
      end

      SOLVE: begin
        // K is odd, so K<<idx flips bit idx of acc and leaves lower bits alone.
        if (diff_shr[0]) begin
          a_d   = a_q | (ONE << idx_q);
          acc_d = acc_q + (K << idx_q);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.OUT_READY) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      s_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign bus.IN_READY  = (state_q == IDLE);
  assign bus.OUT_VALID = (state_q == DONE);
  assign bus.A         = a_q;

endmodule
